// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer: rebuilds WIDTH-bit words from a qualified
// bit stream and offers them on a valid/ready port with sticky overrun detection.
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             msb_first,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CW-1:0]    bit_cnt
);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] sync_word;
  logic             last_bit;
  logic             complete;
  logic             load;
  logic             drop;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b,
                                                input logic             msb);
    if (msb) return {cur[WIDTH-2:0], b};
    return {b, cur[WIDTH-1:1]};
  endfunction

  always_comb begin
    next_word = shift_in(shreg, sin, msb_first);
    sync_word = shift_in('0, sin, msb_first);
    last_bit  = (cnt == CW'(WIDTH - 1));
    complete  = sin_valid && !sync && last_bit;
    load      = complete && (!dout_valid || dout_ready);
    drop      = complete && !load;
  end

  // Assembly: sync restarts the frame and outranks word completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (sync) begin
      shreg <= sin_valid ? sync_word : '0;
      cnt   <= sin_valid ? CW'(1) : '0;
    end else if (sin_valid) begin
      if (last_bit) begin
        shreg <= '0;
        cnt   <= '0;
      end else begin
        shreg <= next_word;
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // Output register: a completing word may replace one being consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= next_word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign bit_cnt = cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer (WIDTH=4): expected words are queued as
// serial stimulus is driven and popped when the DUT presents a completed word.
module tb_sipo_deserializer;
  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          sin;
  logic          sin_valid;
  logic          msb_first;
  logic          sync;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;
  logic          overrun_clr;
  logic [CW-1:0] bit_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .msb_first  (msb_first),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .bit_cnt    (bit_cnt)
  );

  // seq[W-1] is the first bit on the wire.
  function automatic logic [W-1:0] ref_word(input logic [W-1:0] seq, input logic msb);
    logic [W-1:0] r;
    if (msb) return seq;
    for (int i = 0; i < W; i++) r[i] = seq[W-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      sin_valid = 1'b0;
      tick();
    end
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] seq, input int gap);
    for (int i = W - 1; i >= 0; i--) send_bit(seq[i], gap);
  endtask

  task automatic test_reset();
    rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; msb_first = 1'b1; sync = 1'b0;
    dout_ready = 1'b1; overrun_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++; if (dout !== 4'b0000) begin miscompares++; $display("FAIL reset_dout: got %b, expected 0000", dout); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", dout_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    vectors++; if (bit_cnt !== '0) begin miscompares++; $display("FAIL reset_bit_cnt: got %0d, expected 0", bit_cnt); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_msb_first();
    logic [W-1:0] seq = 4'b1011;
    msb_first = 1'b1; dout_ready = 1'b1;
    exp_q.push_back(ref_word(seq, 1'b1));
    for (int i = 0; i < W; i++) begin
      send_bit(seq[W-1-i], 0);
      vectors++;
      if (bit_cnt !== CW'((i + 1) % W)) begin
        miscompares++; $display("FAIL msb_bit_cnt[%0d]: got %0d, expected %0d", i, bit_cnt, (i + 1) % W);
      end
      if (i < W - 1) begin
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL msb_early_valid[%0d]: got %b, expected 0", i, dout_valid); end
      end
    end
    exp_w = pop_exp();
    vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL msb_valid: got %b, expected 1", dout_valid); end
    vectors++; if (dout !== exp_w) begin miscompares++; $display("FAIL msb_dout: got %b, expected %b", dout, exp_w); end
    tick();
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL msb_consume: got %b, expected 0", dout_valid); end
    vectors++; if (dout !== exp_w) begin miscompares++; $display("FAIL msb_dout_hold: got %b, expected %b", dout, exp_w); end
  endtask

  task automatic test_lsb_first();
    msb_first = 1'b0; dout_ready = 1'b1;
    for (int g = 0; g <= 4; g++) begin
      exp_q.push_back(ref_word(4'b1011, 1'b0));
      for (int i = W - 1; i >= 0; i--)
        send_bit(i[0] ? 1'b1 : (i == 2 ? 1'b0 : 1'b1), (g < 4) ? g : int'($urandom_range(0, 3)));
      exp_w = pop_exp();
      vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL lsb_valid[gap%0d]: got %b, expected 1", g, dout_valid); end
      vectors++; if (dout !== exp_w) begin miscompares++; $display("FAIL lsb_dout[gap%0d]: got %b, expected %b", g, dout, exp_w); end
    end
    tick();
    msb_first = 1'b1;
  endtask

  task automatic test_overrun();
    msb_first = 1'b1; dout_ready = 1'b0;
    exp_q.push_back(ref_word(4'b1011, 1'b1));
    send_word(4'b1011, 0);
    exp_w = pop_exp();
    vectors++; if (dout !== exp_w || dout_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_first: got %b/%b, expected %b/1", dout, dout_valid, exp_w); end
    send_word(4'b0110, 0);
    vectors++; if (dout !== 4'b1011) begin miscompares++; $display("FAIL ovr_dout_kept: got %b, expected 1011", dout); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    overrun_clr = 1'b1;
    send_bit(1'b0, 0);
    overrun_clr = 1'b0;
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: got %b, expected 1", overrun); end
    vectors++; if (dout !== 4'b1011 || dout_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_dout_kept2: got %b/%b, expected 1011/1", dout, dout_valid); end
    overrun_clr = 1'b1; dout_ready = 1'b1; tick(); overrun_clr = 1'b0;
    vectors++; if (dout_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_drain: got valid %b overrun %b, expected 0/0", dout_valid, overrun); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3] = '{4'hA, 4'h5, 4'h3};
    msb_first = 1'b1; dout_ready = 1'b0;
    exp_q.push_back(ref_word(4'b1011, 1'b1));
    send_word(4'b1011, 0);
    exp_w = pop_exp();
    vectors++; if (dout !== exp_w || dout_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got %b/%b, expected %b/1", dout, dout_valid, exp_w); end
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    dout_ready = 1'b1;
    exp_q.push_back(ref_word(4'b0110, 1'b1));
    send_bit(1'b0, 0);
    exp_w = pop_exp();
    vectors++; if (dout !== exp_w) begin miscompares++; $display("FAIL b2b_replace: got %b, expected %b", dout, exp_w); end
    vectors++; if (dout_valid !== 1'b1 || overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_flags: got valid %b overrun %b, expected 1/0", dout_valid, overrun); end
    tick();
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_consume: got %b, expected 0", dout_valid); end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ref_word(words[k], 1'b1));
      send_word(words[k], 0);
      exp_w = pop_exp();
      vectors++; if (dout !== exp_w || dout_valid !== 1'b1) begin miscompares++; $display("FAIL stream[%0d]: got %b/%b, expected %b/1", k, dout, dout_valid, exp_w); end
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL stream_overrun: got %b, expected 0", overrun); end
    tick();
  endtask

  task automatic test_sync();
    msb_first = 1'b1; dout_ready = 1'b1;
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    vectors++; if (bit_cnt !== CW'(2)) begin miscompares++; $display("FAIL sync_pre_cnt: got %0d, expected 2", bit_cnt); end
    sync = 1'b1; send_bit(1'b1, 0); sync = 1'b0;
    vectors++; if (bit_cnt !== CW'(1)) begin miscompares++; $display("FAIL sync_cnt: got %0d, expected 1", bit_cnt); end
    send_bit(1'b0, 0); send_bit(1'b0, 0);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL sync_no_word: got %b, expected 0", dout_valid); end
    exp_q.push_back(4'b1001);
    send_bit(1'b1, 0);
    exp_w = pop_exp();
    vectors++; if (dout !== exp_w || dout_valid !== 1'b1) begin miscompares++; $display("FAIL sync_word: got %b/%b, expected %b/1", dout, dout_valid, exp_w); end
    send_bit(1'b1, 0);
    sync = 1'b1; tick(); sync = 1'b0;
    vectors++; if (bit_cnt !== '0) begin miscompares++; $display("FAIL sync_idle_cnt: got %0d, expected 0", bit_cnt); end
  endtask

  task automatic test_reset_mid();
    msb_first = 1'b1; dout_ready = 1'b0;
    exp_q.push_back(ref_word(4'b1011, 1'b1));
    send_word(4'b1011, 0);
    exp_w = pop_exp();
    vectors++; if (dout !== exp_w || dout_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre: got %b/%b, expected %b/1", dout, dout_valid, exp_w); end
    send_bit(1'b1, 0); send_bit(1'b0, 0);
    #2 rst = 1'b1;
    #1;
    vectors++; if (dout !== 4'b0000 || dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out: got %b/%b, expected 0000/0", dout, dout_valid); end
    vectors++; if (overrun !== 1'b0 || bit_cnt !== '0) begin miscompares++; $display("FAIL rst_mid_state: got overrun %b cnt %0d, expected 0/0", overrun, bit_cnt); end
    tick();
    rst = 1'b0;
    dout_ready = 1'b1;
    exp_q.push_back(ref_word(4'b0101, 1'b1));
    send_word(4'b0101, 0);
    exp_w = pop_exp();
    vectors++; if (dout !== exp_w || dout_valid !== 1'b1) begin miscompares++; $display("FAIL rst_after_word: got %b/%b, expected %b/1", dout, dout_valid, exp_w); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_sync();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out deserializer that assembles WIDTH-bit words from a qualified serial bit stream. It presents each word on a valid/ready output port. It is the receive-side counterpart of the team's parallel-load shift register: it sits after a serial link or a shifted-out bit stream and rebuilds the parallel words for downstream logic. It supports selectable bit order, frame resynchronisation and sticky overrun detection.

## Interface
- WIDTH, default 4: word width in bits; legal range WIDTH >= 2.
- CW, default $clog2(WIDTH): width of the bit counter.

- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on every rising edge where this is high.
- msb_first  in  1  1: first received bit lands in dout[WIDTH-1]; 0: first received bit lands in dout[0].
- sync  in  1  frame restart: discards the partial word; the bit sampled in the same cycle, if any, becomes bit 0 of a new word.
- dout  out  WIDTH  completed word; stable while dout_valid=1.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  downstream accepts dout on an edge where dout_valid=1 and dout_ready=1.
- overrun  out  1  sticky flag: a completed word was dropped.
- overrun_clr  in  1  clears overrun.
- bit_cnt  out  CW  number of bits already held for the current word (0..WIDTH-1).

## Operation
- Internal state: shift register shreg[WIDTH-1:0], counter cnt[CW-1:0], output register dout, dout_valid, overrun.
- Reset values: shreg=0, cnt=0, dout=0, dout_valid=0, overrun=0.
- Bit accept, when sin_valid=1:
  - msb_first=1: next = {shreg[WIDTH-2:0], sin}.
  - msb_first=0: next = {sin, shreg[WIDTH-1:1]}.
  - msb_first is applied per bit as sampled. Changing it mid-word gives a mixed-order word and has no other effect.
- Counting:
  - If cnt < WIDTH-1: cnt <= cnt+1 and shreg <= next.
  - If cnt == WIDTH-1: the word is complete (completed word = next), cnt <= 0 and shreg <= 0.
- sync=1 has priority over counting:
  - The partial word is discarded.
  - With sin_valid=1: shreg <= the single-bit shift of sin into a zeroed register, and cnt <= 1.
  - With sin_valid=0: shreg <= 0 and cnt <= 0.
  - sync never produces a completed word.
- Output load on word completion:
  - Load condition: dout_valid=0, or dout_ready=1 in the same cycle.
  - If the load condition holds: dout <= completed word and dout_valid <= 1.
  - Otherwise the completed word is dropped, overrun <= 1, and dout/dout_valid are unchanged.
- Consume: dout_valid=1 and dout_ready=1 with no load in that cycle gives dout_valid <= 0. dout keeps its last value.
- overrun:
  - Set only by a dropped word.
  - Cleared by overrun_clr=1.
  - If a drop and overrun_clr occur in the same cycle, set wins (overrun=1).
- The cycle with sin_valid=0 and sync=0 changes neither shreg nor cnt.
- bit_cnt = cnt.

## Timing
- Latency: the last bit of a word is sampled at edge N; dout and dout_valid=1 are visible after edge N. Zero bubble cycles.
- Sustained throughput: one word per WIDTH consecutive valid bits, with no drops provided dout_ready=1 on each completing edge.
- Word completion and a consume in the same cycle: dout is replaced, dout_valid stays 1, no overrun.
- Reset mid-word or with dout_valid=1: all state returns to reset values immediately (asynchronous). The partial word and the pending output are lost. The first valid bit after rst deasserts is bit 0 of a new word.
- dout_ready is ignored while dout_valid=0, except as part of the load condition.

## Test plan
- WIDTH=4, msb_first=1, dout_ready=1, bits 1,0,1,1 on 4 consecutive valid cycles -> after the 4th edge dout=4'b1011 and dout_valid=1; bit_cnt steps 1,2,3,0.
- WIDTH=4, msb_first=0, same bits 1,0,1,1 -> dout=4'b1101; bits with sin_valid gaps of 0-3 idle cycles between them give the identical result.
- dout_ready=0, send words 1011 then 0110 -> dout holds 1011 with dout_valid=1; 2nd word dropped and overrun=1. Then pulse overrun_clr -> overrun=0. Drop and overrun_clr in the same cycle -> overrun=1.
- dout_valid=1 holding 1011, dout_ready=1 on the edge completing 0110 -> dout=0110, dout_valid stays 1, overrun=0. dout_ready=1 on the next edge -> dout_valid=0.
- msb_first=1: bits 1,1, then sync together with bit 1, then 0,0,1 -> one word only, dout=4'b1001; bit_cnt=1 after the sync edge.
- Two bits in, then assert rst for 1 cycle while dout_valid=1 -> dout=0, dout_valid=0, overrun=0, bit_cnt=0. A following 4-bit word 0,1,0,1 (msb_first=1) -> dout=4'b0101.
